// File: rtl/conv_pkg.sv
// Shared constants and types for the streaming 3x3 Gaussian convolution engine.
package conv_pkg;

    // Kernel edge length
    localparam int K = 3;

    // Extra bits on the accumulator so nine full-width products cannot overflow
    localparam int GUARD = 4;

    // Gaussian weights in units of 1/16
    localparam int KWEIGHT [K][K] = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};

    // Coefficient (i,j) as a Q-format integer: weight * 2^q / 16 (64/128/256 for q=10)
    function automatic int kcoef(input int i, input int j, input int q);
        return (KWEIGHT[i][j] << q) >>> 4;
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

endpackage

// File: rtl/line_buffer.sv
// Shift-register line buffer: dout is the sample written DEPTH shifts ago.
module line_buffer #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;

    // Shift one sample in per accepted pixel; oldest entry falls off the top
    always_ff @(posedge clk) begin
        if (rst)
            mem <= '0;
        else if (shift_en)
            mem <= {mem[DEPTH-2:0], din};
    end

    assign dout = mem[DEPTH-1];

endmodule

// File: rtl/conv_top_core.sv
// Streaming 3x3 Gaussian convolution over an N x N raster image, valid region only.
// Pipeline: accept edge loads the window, next edge registers the nine products,
// next edge registers the shifted sum on data_o.
module conv_top_core
    import conv_pkg::*;
#(
    parameter int N          = 100,
    parameter int DATA_WIDTH = 32,
    parameter int Q          = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  running_o
);

    localparam int DW     = DATA_WIDTH;
    localparam int PW     = 2 * DW;
    localparam int SW     = PW + GUARD;
    localparam int CW     = $clog2(N);
    localparam int STAGES = 2;

    state_t state, state_nxt;
    logic [CW-1:0] row, col;
    logic accept, last_px, out_en;
    logic [DW-1:0] lb1_out, lb2_out;
    logic [K-1:0][K-1:0][DW-1:0] win;       // win[row][col], row 0 = r-2, col 2 = newest
    logic signed [PW-1:0] prod_c [K*K];
    logic [K*K-1:0][PW-1:0] prod;
    logic signed [SW-1:0] acc;
    logic [STAGES:0] vld_pipe, last_pipe;

    assign accept  = ena && valid_i && (state != DONE);
    assign last_px = (row == CW'(N-1)) && (col == CW'(N-1));
    assign out_en  = (row >= CW'(2)) && (col >= CW'(2));

    // Rows r-1 and r-2 at the current column
    line_buffer #(.DEPTH(N), .WIDTH(DW)) u_lb1 (
        .clk(clk), .rst(rst), .shift_en(accept), .din(data_i), .dout(lb1_out)
    );
    line_buffer #(.DEPTH(N), .WIDTH(DW)) u_lb2 (
        .clk(clk), .rst(rst), .shift_en(accept), .din(lb1_out), .dout(lb2_out)
    );

    // Raster position of the pixel being accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            if (col == CW'(N-1)) begin
                col <= '0;
                row <= (row == CW'(N-1)) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Slide the 3x3 window left and load the new column (r-2, r-1, r)
    always_ff @(posedge clk) begin
        if (rst) begin
            win <= '0;
        end else if (accept) begin
            for (int i = 0; i < K; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= win[i][2];
            end
            win[0][2] <= lb2_out;
            win[1][2] <= lb1_out;
            win[2][2] <= data_i;
        end
    end

    // Full-width signed products of window and kernel
    always_comb begin
        prod_c = '{default: '0};
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                prod_c[i*K+j] = $signed({{DW{win[i][j][DW-1]}}, win[i][j]}) * $signed(PW'(kcoef(i, j, Q)));
    end

    // Stage 1 register: products
    always_ff @(posedge clk) begin
        if (rst)
            prod <= '0;
        else
            for (int k = 0; k < K*K; k++)
                prod[k] <= prod_c[k];
    end

    // Guard-bit accumulation of the nine products
    always_comb begin
        acc = '0;
        for (int k = 0; k < K*K; k++)
            acc = acc + SW'($signed(prod[k]));
    end

    // Stage 2 register: shift back to Q format, wrap to DW; valid/last tags ride alongside
    always_ff @(posedge clk) begin
        if (rst) begin
            data_o    <= '0;
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[STAGES-1:0], accept && out_en};
            last_pipe <= {last_pipe[STAGES-1:0], accept && last_px};
            if (vld_pipe[STAGES-1])
                data_o <= DW'(acc >>> Q);
        end
    end

    assign valid_o   = vld_pipe[STAGES];
    assign running_o = (state == RUN);

    // Frame state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // IDLE -> RUN on first pixel, RUN -> DONE once the last result has been presented
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (valid_o && last_pipe[STAGES]) state_nxt = DONE;
            default: state_nxt = state;
        endcase
    end

endmodule

// File: tb/tb_conv_top_core.sv
// Scoreboard bench for conv_top_core: driver pushes hand-derived expected results,
// a negedge monitor pops and compares value and 2-edge latency.
module tb_conv_top_core;

    localparam int N  = 100;
    localparam int DW = 32;
    localparam int Q  = 10;

    logic          clk = 0;
    logic          rst = 1;
    logic          ena = 0;
    logic          valid_i = 0;
    logic [DW-1:0] data_i = '0;
    logic [DW-1:0] data_o;
    logic          valid_o, running_o;

    always #5 clk = ~clk;

    conv_top_core #(.N(N), .DATA_WIDTH(DW), .Q(Q)) dut (
        .clk(clk), .rst(rst), .ena(ena), .data_i(data_i), .valid_i(valid_i),
        .data_o(data_o), .valid_o(valid_o), .running_o(running_o)
    );

    typedef struct {int val; int edge_n;} exp_t;
    exp_t q[$];

    int checks = 0, errors = 0;
    int edge_cnt = 0, out_cnt = 0, rises = 0;
    logic rst_seen = 0, prev_run = 0;
    logic [DW-1:0] last_data = '0;

    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        rst_seen <= rst;
    end

    // Pixel patterns: 0 constant 1.0, 1 column ramp, 2 impulse at (50,50), 3 constant -2.0
    function automatic logic [DW-1:0] pix(input int pat, input int r, input int c);
        case (pat)
            0:       return DW'(1024);
            1:       return DW'(c * 1024);
            2:       return (r == 50 && c == 50) ? DW'(16384) : '0;
            default: return DW'(-2048);
        endcase
    endfunction

    // Hand-derived result for the window centred at (rr,cc)
    function automatic int exp_val(input int pat, input int rr, input int cc);
        int dr, dc;
        dr = (rr > 50) ? rr - 50 : 50 - rr;
        dc = (cc > 50) ? cc - 50 : 50 - cc;
        case (pat)
            0:       return 1024;
            1:       return cc * 1024;
            2:       return (dr <= 1 && dc <= 1) ? (4096 >> (dr + dc)) : 0;
            default: return -2048;
        endcase
    endfunction

    // Monitor: reset state, output scoreboard, latency, hold, running bracket
    always @(negedge clk) begin
        exp_t e;
        if (rst_seen) begin
            checks++;
            if (data_o !== '0 || valid_o !== 1'b0 || running_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_state: data_o=%0d valid_o=%b running_o=%b, required 0/0/0",
                         $signed(data_o), valid_o, running_o);
            end
            last_data = '0;
            prev_run  = 0;
        end else begin
            if (running_o && !prev_run) rises++;
            prev_run = running_o;
            if (valid_o) begin
                out_cnt++;
                checks++;
                if (running_o !== 1'b1) begin
                    errors++;
                    $display("FAIL valid_outside_run: running_o=%b, required 1", running_o);
                end
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: data_o=%0d at edge %0d, none expected",
                             $signed(data_o), edge_cnt);
                end else begin
                    e = q.pop_front();
                    if ($signed(data_o) !== e.val || edge_cnt != e.edge_n + 2) begin
                        errors++;
                        $display("FAIL result: got %0d at edge %0d, required %0d at edge %0d",
                                 $signed(data_o), edge_cnt, e.val, e.edge_n + 2);
                    end
                end
                last_data = data_o;
            end else begin
                checks++;
                if (data_o !== last_data) begin
                    errors++;
                    $display("FAIL hold: data_o=%0d, required %0d", $signed(data_o), $signed(last_data));
                end
            end
        end
    end

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1; ena = 0; valid_i = 0;
        #1 q.delete();
        repeat (cycles) @(negedge clk);
        rst = 0;
        out_cnt = 0;
        rises = 0;
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    // Feed one frame; gaps toggles ena 1,0; stop_at >= 0 abandons the frame at that pixel
    task automatic run_frame(input int pat, input bit gaps, input int stop_at);
        int idx = 0;
        bit ph = 0, run_chk = 0, drained = 0;
        exp_t e;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (idx == stop_at) return;
                forever begin
                    @(negedge clk);
                    if (run_chk) begin
                        run_chk = 0;
                        check("running_rise", int'(running_o), 1);
                    end
                    valid_i = 1;
                    data_i  = pix(pat, r, c);
                    if (gaps) begin ena = !ph; ph = !ph; end
                    else ena = 1;
                    if (ena) break;
                end
                if (r >= 2 && c >= 2) begin
                    e.val = exp_val(pat, r - 1, c - 1);
                    e.edge_n = edge_cnt + 1;
                    q.push_back(e);
                end
                if (idx == 0) run_chk = 1;
                idx++;
            end
        end
        @(negedge clk);
        ena = 0; valid_i = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (q.size() == 0) begin drained = 1; break; end
            @(negedge clk);
        end
        check("drain", int'(drained), 1);
        check("running_at_last", int'(running_o), 1);
        @(negedge clk);
        check("running_fall", int'(running_o), 0);
        check("output_count", out_cnt, (N - 2) * (N - 2));
        check("running_intervals", rises, 1);
        // DONE is sticky: further pixels are ignored
        ena = 1; valid_i = 1; data_i = DW'(5000);
        repeat (5) @(negedge clk);
        check("done_sticky", int'(running_o), 0);
        ena = 0; valid_i = 0;
    endtask

    initial begin
        rst = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        run_frame(0, 0, -1); do_reset(2);
        run_frame(1, 0, -1); do_reset(2);
        run_frame(2, 0, -1); do_reset(2);
        run_frame(3, 0, -1); do_reset(2);
        run_frame(0, 1, -1); do_reset(2);
        run_frame(1, 0, 5000); do_reset(1);
        run_frame(1, 0, -1);
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
